// File: rtl/rgb_led_sequencer.sv
// Wishbone master that plays a table of 6-bit RGB colour words into the LED PWM peripheral.
// Optional ack timeout with sticky error flag: define RGB_SEQ_TIMEOUT_EN.
module rgb_led_sequencer #(
  parameter int DEPTH   = 8,
  parameter int HOLD_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [$clog2(DEPTH)-1:0] len_i,
  input  logic [HOLD_W-1:0]        hold_i,
  input  logic                     pat_we_i,
  input  logic [$clog2(DEPTH)-1:0] pat_addr_i,
  input  logic [5:0]               pat_dat_i,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [7:0]               wb_dat_o,
  input  logic                     wb_ack_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH)-1:0] idx_o,
  output logic                     err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     len_q, len_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [7:0]        dat_q, dat_d;
  logic [5:0]        tbl_q [DEPTH];

`ifdef RGB_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     wcnt_q, wcnt_d;
  logic              err_q, err_d;
`endif

  // Next-state and next-output logic for the sequencing FSM
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    we_d    = we_q;
    dat_d   = dat_q;
`ifdef RGB_SEQ_TIMEOUT_EN
    wcnt_d  = wcnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          len_d   = len_i;
          hold_d  = hold_i;
          idx_d   = {AW{1'b0}};
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        // Reads the pre-edge table value, so a same-cycle table write is not seen here
        dat_d   = {2'b00, tbl_q[idx_q]};
        stb_d   = 1'b1;
        we_d    = 1'b1;
        state_d = WRITE;
`ifdef RGB_SEQ_TIMEOUT_EN
        wcnt_d  = {TW{1'b0}};
`endif
      end
      WRITE: begin
        if (wb_ack_i) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = hold_q;
          state_d = HOLD;
`ifdef RGB_SEQ_TIMEOUT_EN
        end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = hold_q;
          err_d   = 1'b1;
          state_d = HOLD;
        end else begin
          wcnt_d  = wcnt_q + TW'(1);
        end
`else
        end else begin
          state_d = WRITE;
        end
`endif
      end
      HOLD: begin
        if (cnt_q != {HOLD_W{1'b0}}) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (!enable_i) begin
          state_d = IDLE;
        end else begin
          idx_d   = (idx_q == len_q) ? {AW{1'b0}} : idx_q + AW'(1);
          state_d = FETCH;
        end
      end
      default: begin
        stb_d   = 1'b0;
        we_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM and Wishbone output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= {AW{1'b0}};
      len_q   <= {AW{1'b0}};
      hold_q  <= {HOLD_W{1'b0}};
      cnt_q   <= {HOLD_W{1'b0}};
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      dat_q   <= 8'h00;
`ifdef RGB_SEQ_TIMEOUT_EN
      wcnt_q  <= {TW{1'b0}};
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
`ifdef RGB_SEQ_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Pattern table, writable in every state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= 6'h00;
      end
    end else if (pat_we_i) begin
      tbl_q[pat_addr_i] <= pat_dat_i;
    end
  end

  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_dat_o = dat_q;
  assign busy_o   = (state_q != IDLE);
  assign idx_o    = idx_q;
`ifdef RGB_SEQ_TIMEOUT_EN
  assign err_o    = err_q;
`else
  assign err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Directed self-checking bench for rgb_led_sequencer (DEPTH=8, HOLD_W=16, TIMEOUT=15).
module tb_rgb_led_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic [2:0]  len_i = 3'd0;
  logic [15:0] hold_i = 16'd0;
  logic        pat_we_i = 1'b0;
  logic [2:0]  pat_addr_i = 3'd0;
  logic [5:0]  pat_dat_i = 6'd0;
  logic        wb_stb_o, wb_we_o, busy_o, err_o;
  logic [7:0]  wb_dat_o;
  logic        wb_ack_i = 1'b0;
  logic [2:0]  idx_o;

  int n_cmp = 0;
  int n_mis = 0;

  rgb_led_sequencer #(.DEPTH(8), .HOLD_W(16), .TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .len_i(len_i), .hold_i(hold_i),
    .pat_we_i(pat_we_i), .pat_addr_i(pat_addr_i), .pat_dat_i(pat_dat_i),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i),
    .busy_o(busy_o), .idx_o(idx_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic write_tbl(input logic [2:0] a, input logic [5:0] d);
    @(negedge clk_i);
    pat_we_i = 1'b1; pat_addr_i = a; pat_dat_i = d;
    @(negedge clk_i);
    pat_we_i = 1'b0;
  endtask

  // n = number of negedges with stb low before stb is seen high; -1 on timeout
  task automatic wait_stb(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (wb_stb_o === 1'b1) return;
      n++;
    end
    n = -1;
  endtask

  task automatic drain(output bit ok);
    enable_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_i);
      if (busy_o === 1'b0) begin
        ok = 1'b1;
        wb_ack_i = 1'b0;
        return;
      end
      wb_ack_i = wb_stb_o;
    end
    wb_ack_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    n_cmp++; if (wb_stb_o !== 1'b0) begin n_mis++; $display("FAIL reset_stb: got %b exp 0", wb_stb_o); end
    n_cmp++; if (wb_we_o !== 1'b0) begin n_mis++; $display("FAIL reset_we: got %b exp 0", wb_we_o); end
    n_cmp++; if (wb_dat_o !== 8'h00) begin n_mis++; $display("FAIL reset_dat: got %h exp 00", wb_dat_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
    n_cmp++; if (idx_o !== 3'd0) begin n_mis++; $display("FAIL reset_idx: got %0d exp 0", idx_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b exp 0", err_o); end
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL idle_busy: got %b exp 0", busy_o); end
  endtask

  task automatic test_sequence;
    logic [7:0] exp_dat [4];
    logic [2:0] exp_idx [4];
    int n;
    bit ok;
    exp_dat = '{8'h30, 8'h0C, 8'h03, 8'h30};
    exp_idx = '{3'd0, 3'd1, 3'd2, 3'd0};
    write_tbl(3'd0, 6'h30);
    write_tbl(3'd1, 6'h0C);
    write_tbl(3'd2, 6'h03);
    len_i = 3'd2; hold_i = 16'd3; enable_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_stb(n);
      // first stb: FETCH cycle only; later: 3 more HOLD cycles + FETCH after the stb-cleared cycle
      n_cmp++; if (n !== ((k == 0) ? 1 : 4)) begin n_mis++; $display("FAIL seq_gap%0d: got %0d exp %0d", k, n, (k == 0) ? 1 : 4); end
      n_cmp++; if (wb_dat_o !== exp_dat[k]) begin n_mis++; $display("FAIL seq_dat%0d: got %h exp %h", k, wb_dat_o, exp_dat[k]); end
      n_cmp++; if (wb_we_o !== 1'b1) begin n_mis++; $display("FAIL seq_we%0d: got %b exp 1", k, wb_we_o); end
      n_cmp++; if (idx_o !== exp_idx[k]) begin n_mis++; $display("FAIL seq_idx%0d: got %0d exp %0d", k, idx_o, exp_idx[k]); end
      wb_ack_i = 1'b1;
      @(negedge clk_i);
      wb_ack_i = 1'b0;
      n_cmp++; if (wb_stb_o !== 1'b0) begin n_mis++; $display("FAIL seq_stbdrop%0d: got %b exp 0", k, wb_stb_o); end
    end
    drain(ok);
    n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL seq_drain: got %b exp 1", ok); end
  endtask

  task automatic test_stall;
    int n;
    int bad;
    bit ok;
    len_i = 3'd2; hold_i = 16'd0; enable_i = 1'b1;
    wait_stb(n);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (wb_stb_o !== 1'b1 || wb_dat_o !== 8'h30 || idx_o !== 3'd0) bad++;
      @(negedge clk_i);
    end
    n_cmp++; if (bad !== 0) begin n_mis++; $display("FAIL stall_stable: got %0d unstable cycles exp 0", bad); end
    n_cmp++; if (wb_stb_o !== 1'b1) begin n_mis++; $display("FAIL stall_stb: got %b exp 1", wb_stb_o); end
    wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    n_cmp++; if (idx_o !== 3'd0) begin n_mis++; $display("FAIL stall_idx_hold: got %0d exp 0", idx_o); end
    wait_stb(n);
    n_cmp++; if (n !== 1) begin n_mis++; $display("FAIL stall_gap: got %0d exp 1", n); end
    n_cmp++; if (idx_o !== 3'd1) begin n_mis++; $display("FAIL stall_idx_next: got %0d exp 1", idx_o); end
    n_cmp++; if (wb_dat_o !== 8'h0C) begin n_mis++; $display("FAIL stall_dat_next: got %h exp 0c", wb_dat_o); end
    drain(ok);
    n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL stall_drain: got %b exp 1", ok); end
  endtask

  task automatic test_disable_mid_write;
    int n;
    int bad;
    int cnt;
    len_i = 3'd2; hold_i = 16'd3; enable_i = 1'b1;
    wait_stb(n);
    enable_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (wb_stb_o !== 1'b1 || busy_o !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_mis++; $display("FAIL dis_wait: got %0d dropped cycles exp 0", bad); end
    wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    n_cmp++; if (wb_stb_o !== 1'b0) begin n_mis++; $display("FAIL dis_stbdrop: got %b exp 0", wb_stb_o); end
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 30) begin
      cnt++;
      @(negedge clk_i);
    end
    n_cmp++; if (cnt !== 4) begin n_mis++; $display("FAIL dis_hold_len: got %0d exp 4", cnt); end
    bad = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (wb_stb_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_mis++; $display("FAIL dis_quiet: got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_len0;
    int n;
    bit ok;
    write_tbl(3'd0, 6'h15);
    len_i = 3'd0; hold_i = 16'd1; enable_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_stb(n);
      n_cmp++; if (wb_dat_o !== 8'h15) begin n_mis++; $display("FAIL len0_dat%0d: got %h exp 15", k, wb_dat_o); end
      n_cmp++; if (idx_o !== 3'd0) begin n_mis++; $display("FAIL len0_idx%0d: got %0d exp 0", k, idx_o); end
      wb_ack_i = 1'b1;
      @(negedge clk_i);
      wb_ack_i = 1'b0;
    end
    drain(ok);
    n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL len0_drain: got %b exp 1", ok); end
  endtask

  task automatic test_collision;
    int n;
    bit ok;
    write_tbl(3'd0, 6'h01);
    len_i = 3'd0; hold_i = 16'd0;
    @(negedge clk_i);
    enable_i = 1'b1;
    @(negedge clk_i);
    pat_we_i = 1'b1; pat_addr_i = 3'd0; pat_dat_i = 6'h3F;
    @(negedge clk_i);
    pat_we_i = 1'b0;
    n_cmp++; if (wb_stb_o !== 1'b1) begin n_mis++; $display("FAIL coll_stb: got %b exp 1", wb_stb_o); end
    n_cmp++; if (wb_dat_o !== 8'h01) begin n_mis++; $display("FAIL coll_old: got %h exp 01", wb_dat_o); end
    wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    wait_stb(n);
    n_cmp++; if (wb_dat_o !== 8'h3F) begin n_mis++; $display("FAIL coll_new: got %h exp 3f", wb_dat_o); end
    drain(ok);
    n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL coll_drain: got %b exp 1", ok); end
  endtask

  task automatic test_async_reset;
    int n;
    bit ok;
    write_tbl(3'd0, 6'h2A);
    len_i = 3'd0; hold_i = 16'd0; enable_i = 1'b1;
    wait_stb(n);
    n_cmp++; if (wb_dat_o !== 8'h2A) begin n_mis++; $display("FAIL arst_pre: got %h exp 2a", wb_dat_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (wb_stb_o !== 1'b0) begin n_mis++; $display("FAIL arst_stb: got %b exp 0", wb_stb_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL arst_busy: got %b exp 0", busy_o); end
    enable_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    enable_i = 1'b1;
    wait_stb(n);
    n_cmp++; if (wb_dat_o !== 8'h00) begin n_mis++; $display("FAIL arst_tblclr: got %h exp 00", wb_dat_o); end
    drain(ok);
    n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL arst_drain: got %b exp 1", ok); end
  endtask

`ifdef RGB_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    int hi;
    write_tbl(3'd0, 6'h30);
    write_tbl(3'd1, 6'h0C);
    len_i = 3'd1; hold_i = 16'd0; enable_i = 1'b1;
    wait_stb(n);
    hi = 0;
    while (wb_stb_o === 1'b1 && hi < 40) begin
      hi++;
      @(negedge clk_i);
    end
    n_cmp++; if (hi !== 15) begin n_mis++; $display("FAIL to_len: got %0d exp 15", hi); end
    n_cmp++; if (err_o !== 1'b1) begin n_mis++; $display("FAIL to_err: got %b exp 1", err_o); end
    wait_stb(n);
    n_cmp++; if (wb_dat_o !== 8'h0C) begin n_mis++; $display("FAIL to_next: got %h exp 0c", wb_dat_o); end
    n_cmp++; if (err_o !== 1'b1) begin n_mis++; $display("FAIL to_sticky: got %b exp 1", err_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (wb_stb_o !== 1'b0) begin n_mis++; $display("FAIL to_arst_stb: got %b exp 0", wb_stb_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL to_arst_err: got %b exp 0", err_o); end
    enable_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_disable_mid_write();
    test_len0();
    test_collision();
    test_async_reset();
`ifdef RGB_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rgb_led_sequencer.md
Name: rgb_led_sequencer

Overview:
Wishbone master that drives the RGB LED PWM peripheral through a programmable colour pattern. Holds a small table of 6-bit colour words (R[5:4], G[3:2], B[1:0]), writes each entry to the peripheral with a full stb/ack handshake, then waits a programmable number of cycles before the next entry. Sits between the soft-CPU config registers and the LED peripheral's Wishbone port, taking LED sequencing off the CPU.

Parameters:
DEPTH, 8, number of pattern entries (power of two, 2..16)
HOLD_W, 16, width of hold counter and hold_i
TIMEOUT, 15, ack wait limit in cycles (used only with RGB_SEQ_TIMEOUT_EN)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  run sequence while high
len_i  in  log2(DEPTH)  index of last entry played (wrap point)
hold_i  in  HOLD_W  hold cycles after each accepted write
pat_we_i  in  1  pattern table write strobe
pat_addr_i  in  log2(DEPTH)  pattern table write address
pat_dat_i  in  6  pattern table write data
wb_stb_o  out  1  Wishbone strobe to LED peripheral
wb_we_o  out  1  Wishbone write enable
wb_dat_o  out  8  Wishbone write data, {2'b00, entry}
wb_ack_i  in  1  Wishbone acknowledge from LED peripheral
busy_o  out  1  high in any state other than IDLE
idx_o  out  log2(DEPTH)  index of entry currently played
err_o  out  1  sticky timeout flag (0 when feature compiled out)

Behaviour:
- Reset (async assert, sync release): state IDLE; wb_stb_o=0, wb_we_o=0, wb_dat_o=0, busy_o=0, idx_o=0, err_o=0; hold counter 0; all table entries 0.
- Table: DEPTH x 6 flops; pat_we_i writes pat_addr_i on the clock edge in any state. A fetch of the same address in the same cycle gets the old value.
- FSM states:
  - IDLE: when enable_i=1, latch len_i into len_q and hold_i into hold_q, set idx=0, go FETCH. Both are re-latched only on leaving IDLE.
  - FETCH (1 cycle): wb_dat_o <= {2'b00, table[idx]}; wb_stb_o <= 1; wb_we_o <= 1; go WRITE. First stb therefore appears 2 cycles after enable_i is sampled high.
  - WRITE: stb, we and dat held stable until wb_ack_i is sampled high. On ack: stb<=0, we<=0, cnt<=hold_q, go HOLD. Ack while stb=0 is ignored.
  - HOLD: while cnt!=0, decrement. At cnt==0: if enable_i=0 go IDLE; else idx <= (idx==len_q) ? 0 : idx+1, go FETCH. HOLD lasts hold_q+1 cycles, so hold_i=0 gives 1 cycle.
- enable_i deassert: never cuts an open transaction. In WRITE, keep waiting for ack, then finish HOLD, then go IDLE. In FETCH, the write still issues. In IDLE, no action.
- len_q > DEPTH-1 cannot occur (width-limited). len_q=0 replays entry 0 forever.
- wb_we_o=1 whenever wb_stb_o=1. The block never reads.
- Async reset mid-transaction: stb drops immediately, FSM goes to IDLE, table is cleared.
- idx_o = idx; busy_o = (state != IDLE).

Optional Feature:
RGB_SEQ_TIMEOUT_EN
- Defined: a wait counter runs in WRITE. If TIMEOUT cycles pass with no ack, drop stb/we, set err_o=1 (sticky until reset), and go to HOLD as if acked. err_o is cleared only by reset.
- Undefined: no counter; WRITE waits forever; err_o tied 0.

Test Plan:
- Reset then enable: table {0x30,0x0C,0x03}, len_i=2, hold_i=3, ack returned the cycle after stb -> wb_dat_o sequence 0x30,0x0C,0x03,0x30...; stb rises 4 cycles after ack falls (1 stb-cleared cycle + 3-cycle hold gap from hold_q+1 HOLD cycles and FETCH).
- Stalled ack: hold wb_ack_i low for 10 cycles -> stb and dat stay stable all 10 cycles; one entry is consumed, and idx advances only after ack.
- Disable mid-WRITE: drop enable_i while stb=1, ack 5 cycles later -> write completes, HOLD runs hold_q+1 cycles, busy_o falls, no further stb.
- Wrap and len=0: len_i=0, table[0]=0x15 -> every write carries 0x15; idx_o stays 0.
- Table write collision: pat_we_i to the fetched address on the FETCH cycle with 0x3F (old value 0x01) -> this write sends 0x01; the next visit sends 0x3F.
- With RGB_SEQ_TIMEOUT_EN, TIMEOUT=15, no ack -> stb drops after 15 cycles, err_o=1 and stays 1, sequence continues to the next entry. Async reset mid-WRITE -> stb=0 immediately, err_o=0.
